// File: rtl/force_acc_bank_if.sv
// Accumulate/release bus for force_acc_bank. The optional o_sat_flag exists
// only when FORCE_ACC_SATURATE_EN is defined.
interface force_acc_bank_if #(
  parameter int NUM_REGS    = 8,
  parameter int FORCE_WIDTH = 32,
  parameter int IDX_WIDTH   = $clog2(NUM_REGS)
);
  logic                     i_acc_valid;
  logic [NUM_REGS-1:0]      i_acc_sel;
  logic [3*FORCE_WIDTH-1:0] i_acc_force;
  logic                     i_rel_valid;
  logic [NUM_REGS-1:0]      i_rel_sel;
  logic                     o_rel_sel_ready;
  logic                     o_rel_valid;
  logic                     i_rel_ready;
  logic [3*FORCE_WIDTH-1:0] o_rel_force;
  logic [IDX_WIDTH-1:0]     o_rel_idx;
  logic [NUM_REGS-1:0]      o_occupied;
  logic                     o_err_sel;
`ifdef FORCE_ACC_SATURATE_EN
  logic                     o_sat_flag;
`endif

  modport slave (
    input  i_acc_valid, i_acc_sel, i_acc_force, i_rel_valid, i_rel_sel, i_rel_ready,
`ifdef FORCE_ACC_SATURATE_EN
    output o_sat_flag,
`endif
    output o_rel_sel_ready, o_rel_valid, o_rel_force, o_rel_idx, o_occupied, o_err_sel
  );

  modport master (
    output i_acc_valid, i_acc_sel, i_acc_force, i_rel_valid, i_rel_sel, i_rel_ready,
`ifdef FORCE_ACC_SATURATE_EN
    input  o_sat_flag,
`endif
    input  o_rel_sel_ready, o_rel_valid, o_rel_force, o_rel_idx, o_occupied, o_err_sel
  );
endinterface

// File: rtl/force_acc_bank.sv
// Bank of NUM_REGS {z,y,x} force accumulators with one-hot accumulate and
// registered valid/ready release. FORCE_ACC_SATURATE_EN selects saturating adds.
module force_acc_bank #(
  parameter int NUM_REGS    = 8,
  parameter int FORCE_WIDTH = 32,
  parameter int IDX_WIDTH   = $clog2(NUM_REGS)
) (
  input logic             clk,
  input logic             rst,
  force_acc_bank_if.slave bus
);
  localparam int FW = FORCE_WIDTH;
  localparam int VW = 3 * FORCE_WIDTH;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_t;
  slot_t r_state, w_state_next;

  logic [VW-1:0]        r_entry [NUM_REGS];
  logic [NUM_REGS-1:0]  r_occupied;
  logic [VW-1:0]        r_rel_force;
  logic [IDX_WIDTH-1:0] r_rel_idx;
  logic                 r_err_sel;

  logic                 w_acc_onehot, w_rel_onehot, w_acc_do, w_rel_do;
  logic                 w_rel_valid, w_sel_ready, w_same_entry;
  logic [VW-1:0]        w_acc_entry, w_acc_sum, w_rel_entry, w_rel_value;
  logic [IDX_WIDTH-1:0] w_rel_idx;
  logic [FW-1:0]        w_a, w_b, w_s;
`ifdef FORCE_ACC_SATURATE_EN
  logic                 r_sat_flag, w_sat_any;
`endif

  assign w_acc_onehot = (bus.i_acc_sel != '0) &&
                        ((bus.i_acc_sel & (bus.i_acc_sel - NUM_REGS'(1))) == '0);
  assign w_rel_onehot = (bus.i_rel_sel != '0) &&
                        ((bus.i_rel_sel & (bus.i_rel_sel - NUM_REGS'(1))) == '0);
  assign w_sel_ready  = (!w_rel_valid || bus.i_rel_ready) && !rst;
  assign w_acc_do     = bus.i_acc_valid && w_acc_onehot;
  assign w_rel_do     = bus.i_rel_valid && w_sel_ready && w_rel_onehot;
  assign w_same_entry = w_acc_do && (bus.i_acc_sel == bus.i_rel_sel);
  // A same-entry collision releases the post-add value so no increment is lost.
  assign w_rel_value  = w_same_entry ? w_acc_sum : w_rel_entry;

  always_comb begin
    w_acc_entry = '0;
    w_rel_entry = '0;
    w_rel_idx   = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.i_acc_sel[i]) w_acc_entry = w_acc_entry | r_entry[i];
      if (bus.i_rel_sel[i]) begin
        w_rel_entry = w_rel_entry | r_entry[i];
        w_rel_idx   = w_rel_idx | IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_acc_sum = '0;
    w_a       = '0;
    w_b       = '0;
    w_s       = '0;
`ifdef FORCE_ACC_SATURATE_EN
    w_sat_any = 1'b0;
`endif
    for (int unsigned c = 0; c < 3; c++) begin
      w_a = w_acc_entry[c*FW +: FW];
      w_b = bus.i_acc_force[c*FW +: FW];
      w_s = w_a + w_b;
`ifdef FORCE_ACC_SATURATE_EN
      if ((w_a[FW-1] == w_b[FW-1]) && (w_s[FW-1] != w_a[FW-1])) begin
        w_sat_any = 1'b1;
        w_s = w_a[FW-1] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
      end
`endif
      w_acc_sum[c*FW +: FW] = w_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= SLOT_EMPTY;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_rel_do)                                      w_state_next = SLOT_FULL;
    else if (r_state == SLOT_FULL && bus.i_rel_ready)  w_state_next = SLOT_EMPTY;
  end

  always_comb begin
    w_rel_valid = (r_state == SLOT_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_entry[i] <= '0;
      r_occupied  <= '0;
      r_rel_force <= '0;
      r_rel_idx   <= '0;
      r_err_sel   <= 1'b0;
`ifdef FORCE_ACC_SATURATE_EN
      r_sat_flag  <= 1'b0;
`endif
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_rel_do && bus.i_rel_sel[i]) begin
          r_entry[i]    <= '0;
          r_occupied[i] <= 1'b0;
        end else if (w_acc_do && bus.i_acc_sel[i]) begin
          r_entry[i]    <= w_acc_sum;
          r_occupied[i] <= 1'b1;
        end
      end
      if (w_rel_do) begin
        r_rel_force <= w_rel_value;
        r_rel_idx   <= w_rel_idx;
      end
      if ((bus.i_acc_valid && !w_acc_onehot) || (bus.i_rel_valid && !w_rel_onehot))
        r_err_sel <= 1'b1;
`ifdef FORCE_ACC_SATURATE_EN
      if (w_acc_do && w_sat_any) r_sat_flag <= 1'b1;
`endif
    end
  end

  assign bus.o_rel_valid     = w_rel_valid;
  assign bus.o_rel_sel_ready = w_sel_ready;
  assign bus.o_rel_force     = r_rel_force;
  assign bus.o_rel_idx       = r_rel_idx;
  assign bus.o_occupied      = r_occupied;
  assign bus.o_err_sel       = r_err_sel;
`ifdef FORCE_ACC_SATURATE_EN
  assign bus.o_sat_flag      = r_sat_flag;
`endif
endmodule

// File: tb/tb_force_acc_bank.sv
// Directed self-checking bench for force_acc_bank (8 entries, 32-bit components).
module tb_force_acc_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  force_acc_bank_if #(.NUM_REGS(8), .FORCE_WIDTH(32), .IDX_WIDTH(3)) bus ();

  force_acc_bank #(.NUM_REGS(8), .FORCE_WIDTH(32), .IDX_WIDTH(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [95:0] f3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return {z, y, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_acc_valid = 1'b0;
    bus.i_acc_sel   = '0;
    bus.i_acc_force = '0;
    bus.i_rel_valid = 1'b0;
    bus.i_rel_sel   = '0;
  endtask

  task automatic acc(input logic [7:0] sel, input logic [95:0] f);
    bus.i_acc_valid = 1'b1;
    bus.i_acc_sel   = sel;
    bus.i_acc_force = f;
    tick();
    bus.i_acc_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    bus.i_rel_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.i_rel_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.o_rel_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.o_rel_valid); end
    checks++; if (bus.o_occupied !== 8'h00) begin failures++; $display("FAIL reset_occ got=%h exp=00", bus.o_occupied); end
    checks++; if (bus.o_err_sel !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.o_err_sel); end
    checks++; if (bus.o_rel_force !== 96'h0 || bus.o_rel_idx !== 3'd0) begin failures++; $display("FAIL reset_out got=%h/%0d exp=0/0", bus.o_rel_force, bus.o_rel_idx); end
    checks++; if (bus.o_rel_sel_ready !== 1'b0) begin failures++; $display("FAIL reset_selrdy got=%0b exp=0", bus.o_rel_sel_ready); end
`ifdef FORCE_ACC_SATURATE_EN
    checks++; if (bus.o_sat_flag !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", bus.o_sat_flag); end
`endif
    rst = 1'b0;
    #1;
    checks++; if (bus.o_rel_sel_ready !== 1'b1) begin failures++; $display("FAIL post_reset_selrdy got=%0b exp=1", bus.o_rel_sel_ready); end
  endtask

  task automatic test_accumulate();
    acc(8'h04, f3(5, -3, 7));
    acc(8'h04, f3(5, -3, 7));
    checks++; if (bus.o_occupied !== 8'h04) begin failures++; $display("FAIL acc_occ got=%h exp=04", bus.o_occupied); end
    bus.i_rel_valid = 1'b1; bus.i_rel_sel = 8'h04; bus.i_rel_ready = 1'b1;
    #1;
    checks++; if (bus.o_rel_valid !== 1'b0) begin failures++; $display("FAIL acc_prevalid got=%0b exp=0", bus.o_rel_valid); end
    tick();
    bus.i_rel_valid = 1'b0;
    checks++; if (bus.o_rel_valid !== 1'b1) begin failures++; $display("FAIL acc_relvalid got=%0b exp=1", bus.o_rel_valid); end
    checks++; if (bus.o_rel_force !== f3(10, -6, 14)) begin failures++; $display("FAIL acc_force got=%h exp=%h", bus.o_rel_force, f3(10, -6, 14)); end
    checks++; if (bus.o_rel_idx !== 3'd2) begin failures++; $display("FAIL acc_idx got=%0d exp=2", bus.o_rel_idx); end
    checks++; if (bus.o_occupied !== 8'h00) begin failures++; $display("FAIL acc_occ_clr got=%h exp=00", bus.o_occupied); end
    tick();
    checks++; if (bus.o_rel_valid !== 1'b0) begin failures++; $display("FAIL acc_drain got=%0b exp=0", bus.o_rel_valid); end
    bus.i_rel_valid = 1'b1; bus.i_rel_sel = 8'h04;
    tick();
    bus.i_rel_valid = 1'b0;
    checks++; if (bus.o_rel_valid !== 1'b1 || bus.o_rel_force !== 96'h0) begin failures++; $display("FAIL acc_entry_clr got=%0b/%h exp=1/0", bus.o_rel_valid, bus.o_rel_force); end
    tick();
  endtask

  task automatic test_back_to_back();
    acc(8'h01, f3(1, 0, 0));
    acc(8'h02, f3(9, 0, 0));
    bus.i_rel_valid = 1'b1; bus.i_rel_sel = 8'h01; bus.i_rel_ready = 1'b0;
    tick();
    bus.i_rel_sel = 8'h02;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.o_rel_sel_ready !== 1'b0) begin failures++; $display("FAIL bp_selrdy cyc=%0d got=%0b exp=0", i, bus.o_rel_sel_ready); end
      checks++; if (bus.o_rel_valid !== 1'b1 || bus.o_rel_force !== f3(1, 0, 0) || bus.o_rel_idx !== 3'd0) begin failures++; $display("FAIL bp_hold cyc=%0d got=%0b/%h/%0d exp=1/%h/0", i, bus.o_rel_valid, bus.o_rel_force, bus.o_rel_idx, f3(1, 0, 0)); end
      tick();
    end
    bus.i_rel_ready = 1'b1;
    #1;
    checks++; if (bus.o_rel_sel_ready !== 1'b1) begin failures++; $display("FAIL bp_selrdy_rise got=%0b exp=1", bus.o_rel_sel_ready); end
    tick();
    bus.i_rel_valid = 1'b0;
    checks++; if (bus.o_rel_valid !== 1'b1 || bus.o_rel_force !== f3(9, 0, 0) || bus.o_rel_idx !== 3'd1) begin failures++; $display("FAIL bp_next got=%0b/%h/%0d exp=1/%h/1", bus.o_rel_valid, bus.o_rel_force, bus.o_rel_idx, f3(9, 0, 0)); end
    tick();
    checks++; if (bus.o_rel_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", bus.o_rel_valid); end
  endtask

  task automatic test_collision();
    acc(8'h08, f3(100, 0, 0));
    bus.i_acc_valid = 1'b1; bus.i_acc_sel = 8'h08; bus.i_acc_force = f3(20, 0, 0);
    bus.i_rel_valid = 1'b1; bus.i_rel_sel = 8'h08; bus.i_rel_ready = 1'b1;
    tick();
    checks++; if (bus.o_rel_force !== f3(120, 0, 0) || bus.o_rel_idx !== 3'd3) begin failures++; $display("FAIL coll_same got=%h/%0d exp=%h/3", bus.o_rel_force, bus.o_rel_idx, f3(120, 0, 0)); end
    checks++; if (bus.o_occupied !== 8'h00) begin failures++; $display("FAIL coll_same_occ got=%h exp=00", bus.o_occupied); end
    bus.i_acc_sel = 8'h10; bus.i_acc_force = f3(7, 0, 0);
    tick();
    idle();
    checks++; if (bus.o_rel_force !== 96'h0 || bus.o_occupied !== 8'h10) begin failures++; $display("FAIL coll_diff got=%h/%h exp=0/10", bus.o_rel_force, bus.o_occupied); end
    tick();
    bus.i_rel_valid = 1'b1; bus.i_rel_sel = 8'h10;
    tick();
    idle();
    checks++; if (bus.o_rel_force !== f3(7, 0, 0) || bus.o_rel_idx !== 3'd4) begin failures++; $display("FAIL coll_diff_rel got=%h/%0d exp=%h/4", bus.o_rel_force, bus.o_rel_idx, f3(7, 0, 0)); end
    tick();
  endtask

  task automatic test_invalid_sel();
    do_reset();
    acc(8'b0000_0110, f3(50, 0, 0));
    checks++; if (bus.o_err_sel !== 1'b1 || bus.o_occupied !== 8'h00) begin failures++; $display("FAIL inv_acc got=%0b/%h exp=1/00", bus.o_err_sel, bus.o_occupied); end
    bus.i_rel_valid = 1'b1; bus.i_rel_sel = 8'h02;
    tick();
    checks++; if (bus.o_rel_valid !== 1'b1 || bus.o_rel_force !== 96'h0) begin failures++; $display("FAIL inv_entry1 got=%0b/%h exp=1/0", bus.o_rel_valid, bus.o_rel_force); end
    bus.i_rel_sel = 8'h00;
    #1;
    checks++; if (bus.o_rel_sel_ready !== 1'b1) begin failures++; $display("FAIL inv_rel_selrdy got=%0b exp=1", bus.o_rel_sel_ready); end
    tick();
    checks++; if (bus.o_rel_valid !== 1'b0) begin failures++; $display("FAIL inv_rel_out got=%0b exp=0", bus.o_rel_valid); end
    idle();
    tick();
    tick();
    checks++; if (bus.o_err_sel !== 1'b1) begin failures++; $display("FAIL inv_sticky got=%0b exp=1", bus.o_err_sel); end
    bus.i_rel_valid = 1'b1; bus.i_rel_sel = 8'h04;
    tick();
    idle();
    checks++; if (bus.o_rel_force !== 96'h0 || bus.o_rel_idx !== 3'd2) begin failures++; $display("FAIL inv_entry2 got=%h/%0d exp=0/2", bus.o_rel_force, bus.o_rel_idx); end
    tick();
  endtask

  task automatic test_wrap();
    logic [95:0] exp_f;
`ifdef FORCE_ACC_SATURATE_EN
    exp_f = f3(32'h7FFFFFFF, 0, 0);
`else
    exp_f = f3(32'h80000010, 0, 0);
`endif
    do_reset();
    acc(8'h20, f3(32'h7FFFFFF0, 0, 0));
`ifdef FORCE_ACC_SATURATE_EN
    checks++; if (bus.o_sat_flag !== 1'b0) begin failures++; $display("FAIL sat_early got=%0b exp=0", bus.o_sat_flag); end
`endif
    acc(8'h20, f3(32'h20, 0, 0));
    bus.i_rel_valid = 1'b1; bus.i_rel_sel = 8'h20;
    tick();
    idle();
    checks++; if (bus.o_rel_force !== exp_f || bus.o_rel_idx !== 3'd5) begin failures++; $display("FAIL wrap got=%h/%0d exp=%h/5", bus.o_rel_force, bus.o_rel_idx, exp_f); end
`ifdef FORCE_ACC_SATURATE_EN
    checks++; if (bus.o_sat_flag !== 1'b1) begin failures++; $display("FAIL sat_flag got=%0b exp=1", bus.o_sat_flag); end
`endif
    tick();
  endtask

  task automatic test_reset_midhold();
    acc(8'h40, f3(3, 0, 0));
    acc(8'h00, f3(1, 0, 0));
    checks++; if (bus.o_err_sel !== 1'b1 || bus.o_occupied !== 8'h40) begin failures++; $display("FAIL mh_setup got=%0b/%h exp=1/40", bus.o_err_sel, bus.o_occupied); end
    bus.i_rel_valid = 1'b1; bus.i_rel_sel = 8'h40; bus.i_rel_ready = 1'b0;
    tick();
    bus.i_rel_valid = 1'b0;
    checks++; if (bus.o_rel_valid !== 1'b1 || bus.o_rel_force !== f3(3, 0, 0)) begin failures++; $display("FAIL mh_hold got=%0b/%h exp=1/%h", bus.o_rel_valid, bus.o_rel_force, f3(3, 0, 0)); end
    acc(8'h80, f3(4, 0, 0));
    rst = 1'b1;
    tick();
    checks++; if (bus.o_rel_valid !== 1'b0 || bus.o_occupied !== 8'h00 || bus.o_err_sel !== 1'b0) begin failures++; $display("FAIL mh_reset got=%0b/%h/%0b exp=0/00/0", bus.o_rel_valid, bus.o_occupied, bus.o_err_sel); end
    checks++; if (bus.o_rel_force !== 96'h0 || bus.o_rel_idx !== 3'd0) begin failures++; $display("FAIL mh_reset_out got=%h/%0d exp=0/0", bus.o_rel_force, bus.o_rel_idx); end
    rst = 1'b0;
    bus.i_rel_ready = 1'b1; bus.i_rel_valid = 1'b1; bus.i_rel_sel = 8'h40;
    tick();
    idle();
    checks++; if (bus.o_rel_valid !== 1'b1 || bus.o_rel_force !== 96'h0 || bus.o_rel_idx !== 3'd6) begin failures++; $display("FAIL mh_entry_clr got=%0b/%h/%0d exp=1/0/6", bus.o_rel_valid, bus.o_rel_force, bus.o_rel_idx); end
    tick();
  endtask

  initial begin
    idle();
    bus.i_rel_ready = 1'b1;
    test_reset();
    test_accumulate();
    test_back_to_back();
    test_collision();
    test_invalid_sel();
    test_wrap();
    test_reset_midhold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/force_acc_bank.md
Name: force_acc_bank

Overview:
- Parametrised bank of NUM_REGS neighbour force accumulation registers; successor to the combinational one-hot acc/release select.
- Owns the storage: accumulates incoming force vectors into a one-hot-selected entry and releases a selected entry through a registered valid/ready output.
- Clears each entry on release.
- Sits between the filter/force pipelines and the force writeback path in the MD kernel.

Parameters:
NUM_REGS, 8, number of accumulation entries (matches NUM_FILTERS)
FORCE_WIDTH, 32, two's-complement fixed-point width per force component (x, y, z)
IDX_WIDTH, $clog2(NUM_REGS), width of the released-entry index

Ports:
clk  input  1  single clock
rst  input  1  synchronous, active-high reset
i_acc_valid  input  1  accumulate request this cycle
i_acc_sel  input  NUM_REGS  one-hot entry select for accumulate
i_acc_force  input  3*FORCE_WIDTH  {z,y,x} force increment
i_rel_valid  input  1  release request
i_rel_sel  input  NUM_REGS  one-hot entry select for release
o_rel_sel_ready  output  1  release request accepted this cycle
o_rel_valid  output  1  released force valid
i_rel_ready  input  1  downstream accepts released force
o_rel_force  output  3*FORCE_WIDTH  released {z,y,x} sum
o_rel_idx  output  IDX_WIDTH  index of released entry
o_occupied  output  NUM_REGS  entry has taken at least one accumulate since last clear
o_err_sel  output  1  sticky: non-one-hot select seen on a valid request

Behaviour:
- Reset (rst=1 at posedge): all entries = 0; o_occupied = 0; o_rel_valid = 0; o_rel_force = 0; o_rel_idx = 0; o_err_sel = 0. A reset mid-hold drops the pending output without a handshake.
- o_rel_sel_ready is combinational: (!o_rel_valid || i_rel_ready) && !rst.
- Accumulate: when i_acc_valid and i_acc_sel is one-hot, the entry is updated at the next edge.
  - Each component: entry += increment, computed per component, wrapping at FORCE_WIDTH.
  - The selected o_occupied bit is set.
- Release: the request is accepted when i_rel_valid and o_rel_sel_ready and i_rel_sel is one-hot.
  - Next edge: o_rel_force = entry value, o_rel_idx = encoded index, o_rel_valid = 1.
  - The entry and its o_occupied bit are cleared.
  - Latency: 1 cycle from acceptance to o_rel_valid.
- Output hold: o_rel_valid, o_rel_force and o_rel_idx hold stable until i_rel_ready=1 with o_rel_valid=1.
  - Drain and new acceptance may occur in the same cycle (back-to-back, full throughput).
- Same-entry collision: accumulate and accepted release target the same entry in the same cycle.
  - Released value = entry + increment.
  - Entry ends at 0 and the o_occupied bit ends at 0; no increment is lost.
- Different-entry collision: both operations proceed independently.
- Release request not accepted (output stalled): no state change; the requester must hold i_rel_valid/i_rel_sel.
- Select errors:
  - i_acc_sel not one-hot (zero or multiple bits) with i_acc_valid=1: the accumulate is dropped.
  - i_rel_sel not one-hot with i_rel_valid=1: the release is dropped, and o_rel_sel_ready still reflects only output availability.
  - Either case sets o_err_sel, which clears only on rst.
- Releasing an unoccupied entry is legal: it outputs 0 with o_rel_valid=1.
- No internal state machine beyond the output slot: EMPTY (o_rel_valid=0) <-> FULL (o_rel_valid=1).
  - EMPTY->FULL on acceptance.
  - FULL->EMPTY on drain without acceptance.
  - FULL->FULL on drain with acceptance, or on stall.

Optional Feature:
- Macro FORCE_ACC_SATURATE_EN.
- Defined: each component add saturates to +2^(FORCE_WIDTH-1)-1 / -2^(FORCE_WIDTH-1). This applies to collision sums too. An o_sat_flag output (1 bit, sticky, cleared by rst) is added and set on any saturation.
- Undefined: wrapping add, and no o_sat_flag port.

Test Plan:
- Reset then accumulate x=5,y=-3,z=7 twice into entry 2, release entry 2 with i_rel_ready=1:
  - o_rel_valid one cycle after acceptance, force {14,-6,10}, o_rel_idx=2.
  - Entry 2 reads back 0; o_occupied[2]=0.
- Backpressure: release entry 0 (value x=1) with i_rel_ready=0 for 3 cycles, requesting entry 1 (x=9) meanwhile:
  - o_rel_sel_ready=0 and output stable at x=1.
  - When ready rises, entry 1 is accepted the same cycle; next cycle o_rel_force.x=9, o_rel_idx=1.
- Same-entry collision: entry 3 holds x=100; in one cycle accumulate x=20 and release entry 3:
  - Released x=120; entry 3 = 0; o_occupied[3]=0.
- Invalid select: i_acc_sel=8'b0000_0110 with x=50:
  - No entry changes; o_err_sel=1 and stays 1 until rst.
  - Same check with i_rel_sel=0: no output.
- Wrap/saturate: FORCE_WIDTH=32, entry x=0x7FFFFFF0, add 0x20:
  - Without the macro, x=0x80000010.
  - With FORCE_ACC_SATURATE_EN, x=0x7FFFFFFF and o_sat_flag=1.
- Reset mid-hold: o_rel_valid=1, i_rel_ready=0, assert rst:
  - Next cycle o_rel_valid=0, all entries 0, o_occupied=0, o_err_sel=0.
